kalman_step_timer: RTL and testbench

Parametrised multi-channel step timer for the Kalman controller. Accepts start requests from NUM_CH filter channels (default roll, pitch, yaw), queues them, and runs one channel at a time for that channel's programmable cycle count. Emits a one-cycle done pulse tagged with the finishing channel. Sits between the controller FSM and the Kalman datapath, replacing the single fixed-length timer.

---
 rtl/kalman_timer_pkg.sv | 15 +
 rtl/kalman_ch_arbiter.sv | 25 ++
 rtl/kalman_step_timer.sv | 161 ++++++++++++++++
 tb/tb_kalman_step_timer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/kalman_timer_pkg.sv
// Shared types and constants for the multi-channel Kalman step timer.
package kalman_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

    localparam int CH_ROLL            = 0;
    localparam int CH_PITCH           = 1;
    localparam int CH_YAW             = 2;
    localparam int KALMAN_DUR_DEFAULT = 10;

endpackage

// File: rtl/kalman_ch_arbiter.sv
// Fixed-priority picker: returns the lowest set index of the request vector.
module kalman_ch_arbiter #(
    parameter int NUM_CH  = 3,
    parameter int CH_BITS = 2
) (
    input  logic [NUM_CH-1:0]  req,
    output logic               valid,
    output logic [CH_BITS-1:0] idx
);

    // Scan from the top down so the lowest requesting index wins last.
    always_comb begin
        valid = 1'b0;
        idx   = {CH_BITS{1'b0}};
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = CH_BITS'(i);
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/kalman_step_timer.sv
// Multi-channel step timer: queues per-channel start requests and runs one
// channel at a time for its programmed cycle count, pulsing done at the end.
module kalman_step_timer
    import kalman_timer_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int CNT_BITS = 8,
    parameter int CH_BITS  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       clear,
    input  logic [NUM_CH-1:0]          start,
    input  logic [NUM_CH*CNT_BITS-1:0] dur_cfg,
    output logic                       busy,
    output logic [CH_BITS-1:0]         active_ch,
    output logic                       done,
    output logic [CH_BITS-1:0]         done_ch,
    output logic [NUM_CH-1:0]          pending,
    output logic                       overrun
);

    timer_state_t          state_r, state_n_s;
    logic [CNT_BITS-1:0]   cnt_r, cnt_n_s;
    logic [CNT_BITS-1:0]   dur_r, dur_n_s, dur_sel_s;
    logic [CH_BITS-1:0]    active_r, active_n_s;
    logic [CH_BITS-1:0]    done_ch_r, done_ch_n_s;
    logic [NUM_CH-1:0]     pending_r, pending_n_s;
    logic [NUM_CH-1:0]     req_s, grant_mask_s;
    logic                  busy_r, busy_n_s;
    logic                  done_r, done_n_s;
    logic                  overrun_r, overrun_n_s;
    logic                  grant_valid_s, grant_en_s;
    logic [CH_BITS-1:0]    grant_idx_s;

    assign req_s = pending_r | start;

    kalman_ch_arbiter #(
        .NUM_CH  (NUM_CH),
        .CH_BITS (CH_BITS)
    ) u_arbiter (
        .req   (req_s),
        .valid (grant_valid_s),
        .idx   (grant_idx_s)
    );

    // Duration of the candidate channel and one-hot mask of the granted bit.
    always_comb begin
        dur_sel_s    = {CNT_BITS{1'b0}};
        grant_mask_s = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_idx_s == CH_BITS'(i)) begin
                dur_sel_s       = dur_cfg[i*CNT_BITS +: CNT_BITS];
                grant_mask_s[i] = grant_en_s;
            end else begin
                grant_mask_s[i] = 1'b0;
            end
        end
    end

    // Next-state, counter, queue and output decode; clear overrides everything.
    always_comb begin
        state_n_s   = state_r;
        cnt_n_s     = cnt_r;
        dur_n_s     = dur_r;
        active_n_s  = active_r;
        done_ch_n_s = done_ch_r;
        done_n_s    = 1'b0;
        grant_en_s  = 1'b0;

        case (state_r)
            IDLE: begin
                if (grant_valid_s) begin
                    grant_en_s = 1'b1;
                end else begin
                    state_n_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == dur_r) begin
                    state_n_s   = DONE;
                    done_n_s    = 1'b1;
                    done_ch_n_s = active_r;
                end else begin
                    cnt_n_s = cnt_r + CNT_BITS'(1);
                end
            end
            DONE: begin
                cnt_n_s = {CNT_BITS{1'b0}};
                if (grant_valid_s) begin
                    grant_en_s = 1'b1;
                end else begin
                    state_n_s = IDLE;
                end
            end
            default: begin
                state_n_s = IDLE;
                cnt_n_s   = {CNT_BITS{1'b0}};
            end
        endcase

        // A zero duration would never match the counter, so run it as one cycle.
        if (grant_en_s) begin
            state_n_s  = RUN;
            active_n_s = grant_idx_s;
            dur_n_s    = (dur_sel_s == {CNT_BITS{1'b0}}) ? CNT_BITS'(1) : dur_sel_s;
            cnt_n_s    = CNT_BITS'(1);
        end else begin
            dur_n_s = dur_n_s;
        end

        pending_n_s = req_s & ~grant_mask_s;
        overrun_n_s = overrun_r | (|(start & pending_r & ~grant_mask_s));

        if (clear) begin
            state_n_s   = IDLE;
            cnt_n_s     = {CNT_BITS{1'b0}};
            pending_n_s = {NUM_CH{1'b0}};
            overrun_n_s = 1'b0;
            done_n_s    = 1'b0;
            active_n_s  = active_r;
        end else begin
            overrun_n_s = overrun_n_s;
        end

        busy_n_s = (state_n_s == RUN);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r   <= IDLE;
            cnt_r     <= {CNT_BITS{1'b0}};
            dur_r     <= {CNT_BITS{1'b0}};
            active_r  <= {CH_BITS{1'b0}};
            done_ch_r <= {CH_BITS{1'b0}};
            pending_r <= {NUM_CH{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            state_r   <= state_n_s;
            cnt_r     <= cnt_n_s;
            dur_r     <= dur_n_s;
            active_r  <= active_n_s;
            done_ch_r <= done_ch_n_s;
            pending_r <= pending_n_s;
            busy_r    <= busy_n_s;
            done_r    <= done_n_s;
            overrun_r <= overrun_n_s;
        end
    end

    assign busy      = busy_r;
    assign active_ch = active_r;
    assign done      = done_r;
    assign done_ch   = done_ch_r;
    assign pending   = pending_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_kalman_step_timer.sv
// Randomised and directed bench for kalman_step_timer against a behavioural
// model of the request queue and run/done sequencing.
module tb_kalman_step_timer;
    import kalman_timer_pkg::*;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        clear;
    logic [2:0]  start;
    logic [23:0] dur_cfg;
    logic        busy;
    logic [1:0]  active_ch;
    logic        done;
    logic [1:0]  done_ch;
    logic [2:0]  pending;
    logic        overrun;

    int n_chk  = 0;
    int n_fail = 0;
    bit run_cmp = 1'b0;

    kalman_step_timer dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear     (clear),
        .start     (start),
        .dur_cfg   (dur_cfg),
        .busy      (busy),
        .active_ch (active_ch),
        .done      (done),
        .done_ch   (done_ch),
        .pending   (pending),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a channel is either running with some busy cycles left, or the
    // timer is free (idle or in its done cycle) and may accept the lowest request.
    bit         m_busy = 1'b0;
    bit         m_done = 1'b0;
    bit         m_ovr  = 1'b0;
    int         m_rem  = 0;
    int         m_ch   = 0;
    int         m_dch  = 0;
    logic [2:0] m_pend = 3'b000;
    logic [2:0] m_req, m_gmask;
    int         m_g, m_d;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_ovr = 1'b0; m_rem = 0;
            m_ch = 0; m_dch = 0; m_pend = 3'b000;
        end else if (clear) begin
            m_busy = 1'b0; m_done = 1'b0; m_ovr = 1'b0; m_rem = 0; m_pend = 3'b000;
        end else begin
            m_req   = m_pend | start;
            m_gmask = 3'b000;
            m_done  = 1'b0;
            if (m_busy) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_dch  = m_ch;
                end
            end else if (m_req != 3'b000) begin
                m_g = 0;
                for (int i = 2; i >= 0; i--) if (m_req[i]) m_g = i;
                m_gmask[m_g] = 1'b1;
                m_d    = int'(dur_cfg[m_g*8 +: 8]);
                m_rem  = (m_d == 0) ? 1 : m_d;
                m_busy = 1'b1;
                m_ch   = m_g;
            end
            if ((start & m_pend & ~m_gmask) != 3'b000) m_ovr = 1'b1;
            m_pend = m_req & ~m_gmask;
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("model_busy", 32'(busy), 32'(m_busy));
            chk("model_done", 32'(done), 32'(m_done));
            chk("model_pending", 32'(pending), 32'(m_pend));
            chk("model_overrun", 32'(overrun), 32'(m_ovr));
            chk("model_active_ch", 32'(active_ch), 32'(m_ch));
            if (m_done) chk("model_done_ch", 32'(done_ch), 32'(m_dch));
        end
    end

    int ch2_runs;

    initial begin
        n_rst   = 1'b0;
        clear   = 1'b0;
        start   = 3'b000;
        dur_cfg = {3{8'(KALMAN_DUR_DEFAULT)}};
        @(posedge clk);
        run_cmp = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_pending", 32'(pending), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_active_ch", 32'(active_ch), 32'd0);
        n_rst = 1'b1;

        // Single channel, default duration.
        @(negedge clk); start = 3'b001;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk); start = 3'b000;
            chk("t1_busy", 32'(busy), 32'(c <= 10));
            chk("t1_done", 32'(done), 32'(c == 11));
            if (c == 11) chk("t1_done_ch", 32'(done_ch), 32'(CH_ROLL));
        end

        // Simultaneous requests, durations 4/6/2.
        dur_cfg = {8'd2, 8'd6, 8'd4};
        @(negedge clk); start = 3'b111;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk); start = 3'b000;
            chk("t2_done", 32'(done), 32'(c == 5 || c == 12 || c == 15));
            if (c == 5)  chk("t2_done_ch0", 32'(done_ch), 32'(CH_ROLL));
            if (c == 12) chk("t2_done_ch1", 32'(done_ch), 32'(CH_PITCH));
            if (c == 15) chk("t2_done_ch2", 32'(done_ch), 32'(CH_YAW));
            if (c == 1)  chk("t2_pending_c1", 32'(pending), 32'b110);
            if (c == 6)  chk("t2_pending_c6", 32'(pending), 32'b100);
            if (c == 13) chk("t2_pending_c13", 32'(pending), 32'b000);
        end

        // Zero duration runs for one cycle.
        dur_cfg = {8'd10, 8'd0, 8'd10};
        @(negedge clk); start = 3'b010;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk); start = 3'b000;
            chk("t3_busy", 32'(busy), 32'(c == 1));
            chk("t3_done", 32'(done), 32'(c == 2));
        end

        // Self re-queue is not an overrun; double request on a pending channel is.
        dur_cfg  = {3{8'(KALMAN_DUR_DEFAULT)}};
        ch2_runs = 0;
        @(negedge clk); start = 3'b001;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = (c == 3) ? 3'b001 : ((c == 5 || c == 6) ? 3'b100 : 3'b000);
            if (c == 4) begin
                chk("t4_self_requeue_pending", 32'(pending), 32'b001);
                chk("t4_self_requeue_overrun", 32'(overrun), 32'd0);
            end
            if (c == 7) begin
                chk("t4_overrun", 32'(overrun), 32'd1);
                chk("t4_pending", 32'(pending), 32'b101);
            end
            if (done && done_ch == 2'd2) ch2_runs++;
        end
        chk("t4_ch2_single_run", 32'(ch2_runs), 32'd1);
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        chk("t4_overrun_cleared", 32'(overrun), 32'd0);

        // Clear mid-run with a queued request; coincident start is dropped.
        @(negedge clk); start = 3'b101;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            start = 3'b000;
            clear = 1'b0;
            if (c == 5) begin
                chk("t5_pending_before", 32'(pending), 32'b100);
                clear = 1'b1;
                start = 3'b010;
            end
            if (c == 6) begin
                chk("t5_busy_after", 32'(busy), 32'd0);
                chk("t5_pending_after", 32'(pending), 32'd0);
            end
            if (c >= 6) chk("t5_no_done", 32'(done), 32'd0);
        end

        // Asynchronous reset mid-run, then a fresh run completes.
        @(negedge clk); start = 3'b010;
        @(negedge clk); start = 3'b000;
        @(posedge clk); @(posedge clk);
        #2 n_rst = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_pending", 32'(pending), 32'd0);
        chk("t6_rst_active_ch", 32'(active_ch), 32'd0);
        chk("t6_rst_done", 32'(done), 32'd0);
        @(negedge clk); n_rst = 1'b1;
        @(negedge clk); start = 3'b010;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk); start = 3'b000;
            chk("t6_done", 32'(done), 32'(c == 11));
            if (c == 11) chk("t6_done_ch", 32'(done_ch), 32'(CH_PITCH));
        end

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) start[i] = ($urandom_range(0, 4) == 0);
            clear = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < 3; i++) dur_cfg[i*8 +: 8] = 8'($urandom_range(0, 12));
            end
        end
        @(negedge clk); start = 3'b000; clear = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
